// File: rtl/sld_stream.sv
// sld_stream: walks the scene ROM from address 0 and streams its bytes out through a small prefetch FIFO
module sld_stream #(
  parameter int DEPTH      = 1501,
  parameter int AW         = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  output logic          rd_valid,
  output logic [7:0]    rd_data,
  input  logic          rd_ready,
  output logic          busy,
  output logic          done,
  output logic          over_read
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [AW:0] addr;
  logic [PW:0] cnt;
  logic [PW-1:0] wp, rp;
  logic [7:0] mem [FIFO_DEPTH];
  logic push, pop, last;
  // a same-cycle pop never frees a slot for the push
  assign push = state == FETCH && cnt < (PW+1)'(FIFO_DEPTH);
  assign pop = rd_valid && rd_ready;
  assign last = addr == (AW+1)'(DEPTH-1);
  assign rom_addr = addr[AW-1:0];
  assign rd_valid = cnt != '0;
  assign rd_data = mem[rp];
  assign busy = state == FETCH || state == DRAIN;
  assign done = state == DONE;
  always_comb begin
    state_nx = start ? FETCH :
               (push && last) ? DRAIN :
               (state == DRAIN && pop && cnt == (PW+1)'(1)) ? DONE : state;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      addr <= '0;
      cnt <= '0;
      wp <= '0;
      rp <= '0;
      over_read <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        addr <= '0;
        cnt <= '0;
        wp <= '0;
        rp <= '0;
        over_read <= 1'b0;
      end else begin
        if (push) begin
          mem[wp] <= rom_data;
          wp <= wp + 1'b1;
          addr <= addr + 1'b1;
        end
        if (pop) rp <= rp + 1'b1;
        cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
        if (state == DONE && rd_ready) over_read <= 1'b1;
      end
    end
  end
endmodule
